control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 28 ++
 rtl/control_sequencer.sv | 144 ++++++++++++++
 tb/tb_control_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and its datapath: instruction and flag
// inputs, mux selects, write enables and sequencer status.
interface control_sequencer_if;
  logic [5:0]  opcode;
  logic        zero;
  logic [1:0]  puerto1;
  logic [1:0]  puerto2;
  logic [24:0] contador;
  logic        s_inc, s_inm, we3, s_rel, s_ret, enablebackup;
  logic        selentrada, selsalida, s_cont;
  logic [2:0]  op;
  logic        enable0, enable1, enable2, enable3;
  logic        pc_hold, halted, waiting, call_active, err;

  modport master (
    input  opcode, zero, puerto1, puerto2, contador,
    output s_inc, s_inm, we3, s_rel, s_ret, enablebackup, selentrada, selsalida,
           s_cont, op, enable0, enable1, enable2, enable3,
           pc_hold, halted, waiting, call_active, err
  );

  modport slave (
    output opcode, zero, puerto1, puerto2, contador,
    input  s_inc, s_inm, we3, s_rel, s_ret, enablebackup, selentrada, selsalida,
           s_cont, op, enable0, enable1, enable2, enable3,
           pc_hold, halted, waiting, call_active, err
  );
endinterface

// File: rtl/control_sequencer.sv
// Instruction decoder / sequencer: combinational decode in RUN, a programmable
// wait (WLOAD -> WAIT down-counter), single-level call backup and a sticky HALT.
//
// state    | meaning
// ST_RUN   | decode opcode (or one PC-advance cycle right after a wait)
// ST_WLOAD | load wait counter from contador, PC frozen
// ST_WAIT  | counting down, PC frozen
// ST_HALT  | stopped until reset
module control_sequencer (
  input  logic                        clk,
  input  logic                        reset,
  control_sequencer_if.master         bus
);
  typedef enum logic [1:0] {ST_RUN, ST_WLOAD, ST_WAIT, ST_HALT} state_t;

  localparam logic [5:0] OP_LI   = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b001001;
  localparam logic [5:0] OP_JZ   = 6'b001010;
  localparam logic [5:0] OP_JNZ  = 6'b001011;
  localparam logic [5:0] OP_JR   = 6'b001100;
  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [5:0] OP_IN   = 6'b010000;
  localparam logic [5:0] OP_OUTI = 6'b010001;
  localparam logic [5:0] OP_OUTR = 6'b010010;
  localparam logic [5:0] OP_OUTX = 6'b010011;
  localparam logic [5:0] OP_WAIT = 6'b011000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t      r_state, w_next;
  logic [24:0] r_count;
  logic        r_resume, r_call_active, r_err;
  logic [3:0]  w_en;
  logic        w_set_call, w_clr_call, w_set_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_count       <= '0;
      r_resume      <= 1'b0;
      r_call_active <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state  <= w_next;
      // PC was held at the WAIT instruction; spend one RUN cycle stepping past it
      r_resume <= (r_state == ST_WLOAD || r_state == ST_WAIT) && (w_next == ST_RUN);
      if (r_state == ST_WLOAD)
        r_count <= bus.contador;
      else if (r_state == ST_WAIT && r_count != 25'd0)
        r_count <= r_count - 25'd1;
      if (w_set_call)
        r_call_active <= 1'b1;
      else if (w_clr_call)
        r_call_active <= 1'b0;
      if (w_set_err)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (!r_resume) begin
          if (bus.opcode == OP_WAIT)      w_next = ST_WLOAD;
          else if (bus.opcode == OP_HALT) w_next = ST_HALT;
        end
      end
      ST_WLOAD: w_next = (bus.contador == 25'd0) ? ST_RUN : ST_WAIT;
      ST_WAIT:  if (r_count <= 25'd1) w_next = ST_RUN;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_RUN;
    endcase
  end

  always_comb begin
    bus.s_inc        = 1'b1;
    bus.s_inm        = 1'b0;
    bus.we3          = 1'b0;
    bus.s_rel        = 1'b0;
    bus.s_ret        = 1'b0;
    bus.enablebackup = 1'b0;
    bus.selentrada   = 1'b0;
    bus.selsalida    = 1'b0;
    bus.s_cont       = 1'b0;
    bus.op           = 3'b000;
    bus.pc_hold      = 1'b0;
    w_en             = 4'b0000;
    w_set_call       = 1'b0;
    w_clr_call       = 1'b0;
    w_set_err        = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (!r_resume) begin
            casez (bus.opcode)
              6'b000???: begin bus.op = bus.opcode[2:0]; bus.we3 = 1'b1; end
              OP_LI:     begin bus.s_inm = 1'b1; bus.we3 = 1'b1; end
              OP_J:      bus.s_inc = 1'b0;
              OP_JZ:     bus.s_inc = ~bus.zero;
              OP_JNZ:    bus.s_inc = bus.zero;
              OP_JR:     bus.s_rel = 1'b1;
              OP_CALL: begin
                bus.s_inc = 1'b0;
                // backup register already holds a return address: degrade to J
                if (!r_call_active) begin
                  bus.enablebackup = 1'b1;
                  w_set_call       = 1'b1;
                end else begin
                  w_set_err = 1'b1;
                end
              end
              OP_RET: begin
                if (r_call_active) begin
                  bus.s_ret  = 1'b1;
                  w_clr_call = 1'b1;
                end else begin
                  w_set_err = 1'b1;
                end
              end
              OP_IN:   begin bus.selentrada = 1'b1; bus.we3 = 1'b1; end
              OP_OUTI: w_en[bus.puerto1] = 1'b1;
              OP_OUTR: begin bus.selsalida = 1'b1; w_en[bus.puerto1] = 1'b1; end
              OP_OUTX: begin bus.selsalida = 1'b1; w_en[bus.puerto2] = 1'b1; end
              OP_WAIT: begin bus.s_cont = 1'b1; bus.pc_hold = 1'b1; end
              OP_HALT: bus.pc_hold = 1'b1;
              default: w_set_err = 1'b1;
            endcase
          end
        end
        default: bus.pc_hold = 1'b1;
      endcase
    end
  end

  assign bus.enable0     = w_en[0];
  assign bus.enable1     = w_en[1];
  assign bus.enable2     = w_en[2];
  assign bus.enable3     = w_en[3];
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.waiting     = (r_state == ST_WAIT);
  assign bus.call_active = r_call_active;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: decode table, jumps, call/return,
// wait timing, halt and reset recovery.
module tb_control_sequencer;
  logic clk;
  logic reset;
  integer n_cmp;
  integer n_err;

  control_sequencer_if sif ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.master)
  );

  logic [3:0] en;
  assign en = {sif.enable3, sif.enable2, sif.enable1, sif.enable0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.opcode = 6'b000011;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (sif.we3 !== 1'b0 || sif.pc_hold !== 1'b0 || sif.s_cont !== 1'b0 || sif.s_inc !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outputs we3=%b pc_hold=%b s_cont=%b s_inc=%b want 0 0 0 1",
               sif.we3, sif.pc_hold, sif.s_cont, sif.s_inc);
    end
    n_cmp++;
    if ({sif.halted, sif.waiting, sif.call_active, sif.err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_status got %b want 0000",
               {sif.halted, sif.waiting, sif.call_active, sif.err});
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu_out();
    sif.opcode = 6'b000011;
    @(negedge clk);
    n_cmp++;
    if (sif.op !== 3'b011 || sif.we3 !== 1'b1 || sif.s_inc !== 1'b1 || en !== 4'b0000) begin
      n_err++;
      $display("FAIL alu op=%b we3=%b s_inc=%b en=%b want 011 1 1 0000", sif.op, sif.we3, sif.s_inc, en);
    end
    step();
    sif.opcode = 6'b010001;
    sif.puerto1 = 2'd2;
    sif.puerto2 = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (en !== 4'b0100 || sif.selsalida !== 1'b0 || sif.we3 !== 1'b0) begin
      n_err++;
      $display("FAIL outi en=%b selsalida=%b we3=%b want 0100 0 0", en, sif.selsalida, sif.we3);
    end
    step();
    sif.opcode = 6'b010011;
    sif.puerto1 = 2'd1;
    sif.puerto2 = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (en !== 4'b1000 || sif.selsalida !== 1'b1) begin
      n_err++;
      $display("FAIL outx en=%b selsalida=%b want 1000 1", en, sif.selsalida);
    end
    step();
    sif.opcode = 6'b001000;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inm !== 1'b1 || sif.we3 !== 1'b1 || sif.op !== 3'b000 || en !== 4'b0000) begin
      n_err++;
      $display("FAIL li s_inm=%b we3=%b op=%b en=%b want 1 1 000 0000", sif.s_inm, sif.we3, sif.op, en);
    end
    step();
    sif.opcode = 6'b111000;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inc !== 1'b1 || sif.we3 !== 1'b0 || en !== 4'b0000 || sif.pc_hold !== 1'b0) begin
      n_err++;
      $display("FAIL undef s_inc=%b we3=%b en=%b pc_hold=%b want 1 0 0000 0", sif.s_inc, sif.we3, en, sif.pc_hold);
    end
    step();
    sif.opcode = 6'b000000;
    @(negedge clk);
    n_cmp++;
    if (sif.err !== 1'b1) begin
      n_err++;
      $display("FAIL undef_err err=%b want 1", sif.err);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sif.err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear err=%b want 0", sif.err);
    end
    step();
  endtask

  task automatic test_jumps();
    sif.opcode = 6'b001010;
    sif.zero = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inc !== 1'b0) begin n_err++; $display("FAIL jz_taken s_inc=%b want 0", sif.s_inc); end
    step();
    sif.zero = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inc !== 1'b1) begin n_err++; $display("FAIL jz_not s_inc=%b want 1", sif.s_inc); end
    step();
    sif.opcode = 6'b001011;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inc !== 1'b0) begin n_err++; $display("FAIL jnz_taken s_inc=%b want 0", sif.s_inc); end
    step();
    sif.zero = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sif.s_inc !== 1'b1) begin n_err++; $display("FAIL jnz_not s_inc=%b want 1", sif.s_inc); end
    step();
    sif.opcode = 6'b001100;
    @(negedge clk);
    n_cmp++;
    if (sif.s_rel !== 1'b1 || sif.s_inc !== 1'b1 || sif.we3 !== 1'b0) begin
      n_err++;
      $display("FAIL jr s_rel=%b s_inc=%b we3=%b want 1 1 0", sif.s_rel, sif.s_inc, sif.we3);
    end
    step();
    sif.zero = 1'b0;
  endtask

  task automatic test_call_ret();
    sif.opcode = 6'b001101;
    @(negedge clk);
    n_cmp++;
    if (sif.enablebackup !== 1'b1 || sif.s_inc !== 1'b0 || sif.call_active !== 1'b0) begin
      n_err++;
      $display("FAIL call1 enablebackup=%b s_inc=%b call_active=%b want 1 0 0",
               sif.enablebackup, sif.s_inc, sif.call_active);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (sif.call_active !== 1'b1 || sif.enablebackup !== 1'b0 || sif.s_inc !== 1'b0 || sif.err !== 1'b0) begin
      n_err++;
      $display("FAIL call2 call_active=%b enablebackup=%b s_inc=%b err=%b want 1 0 0 0",
               sif.call_active, sif.enablebackup, sif.s_inc, sif.err);
    end
    step();
    sif.opcode = 6'b001110;
    @(negedge clk);
    n_cmp++;
    if (sif.err !== 1'b1 || sif.s_ret !== 1'b1 || sif.call_active !== 1'b1) begin
      n_err++;
      $display("FAIL ret1 err=%b s_ret=%b call_active=%b want 1 1 1", sif.err, sif.s_ret, sif.call_active);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (sif.call_active !== 1'b0 || sif.s_ret !== 1'b0 || sif.s_inc !== 1'b1) begin
      n_err++;
      $display("FAIL ret2 call_active=%b s_ret=%b s_inc=%b want 0 0 1", sif.call_active, sif.s_ret, sif.s_inc);
    end
    step();
    sif.opcode = 6'b000000;
    @(negedge clk);
    n_cmp++;
    if (sif.call_active !== 1'b0 || sif.err !== 1'b1) begin
      n_err++;
      $display("FAIL ret2_after call_active=%b err=%b want 0 1", sif.call_active, sif.err);
    end
    step();
  endtask

  task automatic test_wait(input logic [24:0] cnt, input int exp_hold, input int exp_wait);
    int holds, conts, waits, pc_seen, blocked;
    holds = 0; conts = 0; waits = 0; pc_seen = 0; blocked = 0;
    sif.opcode = 6'b011000;
    sif.contador = cnt;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      if (sif.pc_hold === 1'b1) begin
        holds++;
        if (sif.s_cont === 1'b1) conts++;
        if (sif.waiting === 1'b1) waits++;
        if (sif.we3 !== 1'b0 || en !== 4'b0000 || sif.s_ret !== 1'b0 || sif.s_rel !== 1'b0) blocked++;
        @(negedge clk);
      end else begin
        pc_seen = 1;
        break;
      end
    end
    n_cmp++;
    if (pc_seen != 1 || holds != exp_hold) begin
      n_err++;
      $display("FAIL wait_hold cnt=%0d hold=%0d released=%0d want hold %0d released 1", cnt, holds, pc_seen, exp_hold);
    end
    n_cmp++;
    if (conts != 1 || waits != exp_wait || blocked != 0) begin
      n_err++;
      $display("FAIL wait_cycles cnt=%0d s_cont=%0d waiting=%0d blocked=%0d want 1 %0d 0",
               cnt, conts, waits, blocked, exp_wait);
    end
    n_cmp++;
    if (sif.s_inc !== 1'b1 || sif.s_cont !== 1'b0 || sif.waiting !== 1'b0) begin
      n_err++;
      $display("FAIL wait_resume s_inc=%b s_cont=%b waiting=%b want 1 0 0", sif.s_inc, sif.s_cont, sif.waiting);
    end
    step();
    sif.opcode = 6'b000001;
    @(negedge clk);
    n_cmp++;
    if (sif.we3 !== 1'b1 || sif.op !== 3'b001 || sif.pc_hold !== 1'b0) begin
      n_err++;
      $display("FAIL wait_decode we3=%b op=%b pc_hold=%b want 1 001 0", sif.we3, sif.op, sif.pc_hold);
    end
    step();
  endtask

  task automatic test_halt();
    sif.opcode = 6'b111111;
    @(negedge clk);
    n_cmp++;
    if (sif.pc_hold !== 1'b1 || sif.we3 !== 1'b0) begin
      n_err++;
      $display("FAIL halt_decode pc_hold=%b we3=%b want 1 0", sif.pc_hold, sif.we3);
    end
    step();
    sif.opcode = 6'b000010;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (sif.halted !== 1'b1 || sif.pc_hold !== 1'b1 || sif.we3 !== 1'b0 || sif.s_inc !== 1'b1) begin
      n_err++;
      $display("FAIL halt_hold halted=%b pc_hold=%b we3=%b s_inc=%b want 1 1 0 1",
               sif.halted, sif.pc_hold, sif.we3, sif.s_inc);
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sif.halted !== 1'b1 || sif.pc_hold !== 1'b0 || sif.we3 !== 1'b0) begin
      n_err++;
      $display("FAIL halt_in_reset halted=%b pc_hold=%b we3=%b want 1 0 0", sif.halted, sif.pc_hold, sif.we3);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sif.halted, sif.waiting, sif.call_active, sif.err} !== 4'b0000 || sif.we3 !== 1'b1 || sif.op !== 3'b010) begin
      n_err++;
      $display("FAIL halt_release status=%b we3=%b op=%b want 0000 1 010",
               {sif.halted, sif.waiting, sif.call_active, sif.err}, sif.we3, sif.op);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    sif.opcode = 6'b011000;
    sif.contador = 25'd1000;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    n_cmp++;
    if (sif.waiting !== 1'b1 || sif.pc_hold !== 1'b1) begin
      n_err++;
      $display("FAIL midwait_active waiting=%b pc_hold=%b want 1 1", sif.waiting, sif.pc_hold);
    end
    step();
    reset = 1'b1;
    sif.opcode = 6'b000000;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sif.waiting !== 1'b0 || sif.pc_hold !== 1'b0 || sif.halted !== 1'b0 || sif.we3 !== 1'b1) begin
      n_err++;
      $display("FAIL midwait_reset waiting=%b pc_hold=%b halted=%b we3=%b want 0 0 0 1",
               sif.waiting, sif.pc_hold, sif.halted, sif.we3);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    sif.opcode = 6'b000000;
    sif.zero = 1'b0;
    sif.puerto1 = 2'd0;
    sif.puerto2 = 2'd0;
    sif.contador = 25'd0;
    test_reset();
    test_alu_out();
    test_jumps();
    test_call_ret();
    test_wait(25'd3, 5, 3);
    test_wait(25'd0, 2, 0);
    test_wait(25'd1, 3, 1);
    test_halt();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
